// File: rtl/scr1_dmi_chain_pkg.sv
// Shared debug definitions for the DMI scan chain: chain IDs, DTMCS layout,
// DMI op/status encodings and the access-register geometry.
package scr1_dmi_chain_pkg;

  localparam int SCR1_DBG_DMI_CH_ID_WIDTH = 2;

  localparam logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] DMI_CH_ID_DTMCS      = 2'd0;
  localparam logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] DMI_CH_ID_DMI_ACCESS = 2'd1;

  localparam int DMI_SR_WIDTH   = 41;
  localparam int DMI_DATA_WIDTH = 32;
  localparam int DMI_OP_WIDTH   = 2;
  localparam int DTMCS_WIDTH    = 32;

  // DTMCS field positions
  localparam int DTMCS_DMIHARDRESET_BIT = 17;
  localparam int DTMCS_DMIRESET_BIT     = 16;
  localparam int DTMCS_IDLE_LSB         = 12;
  localparam int DTMCS_DMISTAT_LSB      = 10;
  localparam int DTMCS_ABITS_LSB        = 4;
  localparam int DTMCS_VERSION_LSB      = 0;

  localparam logic [2:0] DTMCS_IDLE_VAL    = 3'd1;
  localparam logic [5:0] DTMCS_ABITS_VAL   = 6'd7;
  localparam logic [3:0] DTMCS_VERSION_VAL = 4'd1;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSV   = 2'd3
  } dmi_op_e;

  localparam logic [1:0] DMI_STAT_OK   = 2'b00;
  localparam logic [1:0] DMI_STAT_BUSY = 2'b11;

  typedef enum logic {
    DMI_FSM_IDLE = 1'b0,
    DMI_FSM_REQ  = 1'b1
  } dmi_fsm_e;

  // dmihardreset/dmireset always read back as zero
  function automatic logic [DTMCS_WIDTH-1:0] dtmcs_word(input logic [1:0] dmistat);
    logic [DTMCS_WIDTH-1:0] w;
    w = '0;
    w[DTMCS_IDLE_LSB    +: 3] = DTMCS_IDLE_VAL;
    w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
    w[DTMCS_ABITS_LSB   +: 6] = DTMCS_ABITS_VAL;
    w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION_VAL;
    return w;
  endfunction

endpackage

// File: rtl/scr1_dmi_chain.sv
// DMI scan chain: DTMCS / DMI_ACCESS shift register with a two-state
// request FSM towards the Debug Module and a sticky busy flag.
module scr1_dmi_chain
  import scr1_dmi_chain_pkg::*;
#(
  parameter int SCR1_DMI_ABITS = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                dmi_ch_sel_core,
  input  logic [SCR1_DBG_DMI_CH_ID_WIDTH-1:0] dmi_ch_id_core,
  input  logic                                dmi_ch_capture_core,
  input  logic                                dmi_ch_shift_core,
  input  logic                                dmi_ch_update_core,
  input  logic                                dmi_ch_tdi_core,
  output logic                                dmi_ch_tdo_core,
  output logic                                dmi_req,
  output logic                                dmi_req_wr,
  output logic [SCR1_DMI_ABITS-1:0]           dmi_req_addr,
  output logic [DMI_DATA_WIDTH-1:0]           dmi_req_wdata,
  input  logic                                dmi_ack,
  input  logic [DMI_DATA_WIDTH-1:0]           dmi_rdata
);

  dmi_fsm_e                  fsm_q, fsm_d;
  logic [DMI_SR_WIDTH-1:0]   sr_q, sr_d;
  logic                      sticky_q, sticky_d;
  logic [SCR1_DMI_ABITS-1:0] addr_q, addr_d;
  logic [DMI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DMI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      wr_q, wr_d;

  logic    ch_dtmcs;
  logic    ch_dmi;
  logic    busy;
  dmi_op_e sr_op;

  assign ch_dtmcs = (dmi_ch_id_core == DMI_CH_ID_DTMCS);
  assign ch_dmi   = (dmi_ch_id_core == DMI_CH_ID_DMI_ACCESS);
  assign busy     = sticky_q || (fsm_q != DMI_FSM_IDLE);
  assign sr_op    = dmi_op_e'(sr_q[DMI_OP_WIDTH-1:0]);

  always_comb begin
    fsm_d    = fsm_q;
    sr_d     = sr_q;
    sticky_d = sticky_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;

    if (dmi_ch_sel_core) begin
      if (dmi_ch_capture_core) begin
        if (ch_dtmcs) begin
          sr_d = {{(DMI_SR_WIDTH-DTMCS_WIDTH){1'b0}},
                  dtmcs_word(sticky_q ? DMI_STAT_BUSY : DMI_STAT_OK)};
        end else if (ch_dmi) begin
          // status is taken from registered state, so a same-cycle ack still reads busy
          sr_d = {addr_q, rdata_q, busy ? DMI_STAT_BUSY : DMI_STAT_OK};
          if (fsm_q == DMI_FSM_REQ) sticky_d = 1'b1;
        end else begin
          sr_d = '0;
        end
      end else if (dmi_ch_shift_core) begin
        if (ch_dmi) begin
          sr_d = {dmi_ch_tdi_core, sr_q[DMI_SR_WIDTH-1:1]};
        end else begin
          sr_d = {sr_q[DMI_SR_WIDTH-1:DTMCS_WIDTH], dmi_ch_tdi_core, sr_q[DTMCS_WIDTH-1:1]};
        end
      end else if (dmi_ch_update_core) begin
        if (ch_dtmcs) begin
          if (sr_q[DTMCS_DMIRESET_BIT]) sticky_d = 1'b0;
        end else if (ch_dmi) begin
          // an update landing on an in-flight request is discarded and flagged
          if (fsm_q == DMI_FSM_REQ) begin
            sticky_d = 1'b1;
          end else if (!sticky_q && (sr_op == DMI_OP_READ || sr_op == DMI_OP_WRITE)) begin
            addr_d  = sr_q[DMI_SR_WIDTH-1 -: SCR1_DMI_ABITS];
            wdata_d = sr_q[DMI_OP_WIDTH +: DMI_DATA_WIDTH];
            wr_d    = (sr_op == DMI_OP_WRITE);
            fsm_d   = DMI_FSM_REQ;
          end
        end
      end
    end

    if (fsm_q == DMI_FSM_REQ && dmi_ack) begin
      fsm_d = DMI_FSM_IDLE;
      if (!wr_q) rdata_d = dmi_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= DMI_FSM_IDLE;
      sr_q     <= '0;
      sticky_q <= 1'b0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      sr_q     <= sr_d;
      sticky_q <= sticky_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  assign dmi_ch_tdo_core = sr_q[0];
  assign dmi_req         = (fsm_q == DMI_FSM_REQ);
  assign dmi_req_wr      = wr_q;
  assign dmi_req_addr    = addr_q;
  assign dmi_req_wdata   = wdata_q;

endmodule

// File: tb/tb_scr1_dmi_chain.sv
// Directed plus randomized bench for scr1_dmi_chain against a transaction-level
// model of the DTM (last address, last read data, sticky busy).
module tb_scr1_dmi_chain;
  import scr1_dmi_chain_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  ch_id = 2'd0;
  logic        cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic        tdo;
  logic        req, req_wr;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;

  int total  = 0;
  int passed = 0;

  // reference model state
  logic [6:0]  m_addr   = '0;
  logic [31:0] m_rdata  = '0;
  logic        m_sticky = 1'b0;

  scr1_dmi_chain #(.SCR1_DMI_ABITS(7)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dmi_ch_sel_core     (sel),
    .dmi_ch_id_core      (ch_id),
    .dmi_ch_capture_core (cap),
    .dmi_ch_shift_core   (shf),
    .dmi_ch_update_core  (upd),
    .dmi_ch_tdi_core     (tdi),
    .dmi_ch_tdo_core     (tdo),
    .dmi_req             (req),
    .dmi_req_wr          (req_wr),
    .dmi_req_addr        (req_addr),
    .dmi_req_wdata       (req_wdata),
    .dmi_ack             (ack),
    .dmi_rdata           (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] dtmcs_exp(input logic sticky);
    return (32'd1 << 12) + ((sticky ? 32'd3 : 32'd0) << 10) + (32'd7 << 4) + 32'd1;
  endfunction

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return (64'(a) << 34) | (64'(d) << 2) | 64'(op);
  endfunction

  task automatic capture(input logic [1:0] id);
    @(negedge clk);
    sel = 1'b1; ch_id = id; cap = 1'b1;
    @(negedge clk);
    cap = 1'b0;
  endtask

  task automatic scan(input int len, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < len; i++) begin
      dout[i] = tdo;
      shf = 1'b1; tdi = din[i];
      @(negedge clk);
    end
    shf = 1'b0;
  endtask

  task automatic update(input logic [1:0] id);
    sel = 1'b1; ch_id = id; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] r);
    int n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req) check("ack_wait_req", 64'(req), 64'd1);
    ack = 1'b1; rdata = r;
    @(negedge clk);
    ack = 1'b0; rdata = $urandom;
    check("req_drop_after_ack", 64'(req), 64'd0);
  endtask

  logic [63:0] so;
  logic [6:0]  a;
  logic [31:0] d, r;
  logic [1:0]  op;

  initial begin
    // reset
    #2 rst = 1'b1;
    #1;
    check("rst_req", 64'(req), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", 64'(req), 64'd0);

    // DTMCS readout
    capture(DMI_CH_ID_DTMCS);
    scan(32, 64'd0, so);
    check("dtmcs_idle", so, 64'(dtmcs_exp(1'b0)));

    // directed read of 0x10
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h10, 32'h0, 2'd1), so);
    check("req_before_update", 64'(req), 64'd0);
    update(DMI_CH_ID_DMI_ACCESS);
    check("rd_req", 64'(req), 64'd1);
    check("rd_wr", 64'(req_wr), 64'd0);
    check("rd_addr", 64'(req_addr), 64'h10);
    m_addr = 7'h10;
    do_ack(32'hDEADBEEF);
    m_rdata = 32'hDEADBEEF;
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h00, 32'h0, 2'd0), so);
    check("rd_capture", so, dmi_word(m_addr, 32'hDEADBEEF, 2'b00));
    update(DMI_CH_ID_DMI_ACCESS);
    check("nop_no_req", 64'(req), 64'd0);

    // directed write of 0x12345678 to 0x04
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h04, 32'h12345678, 2'd2), so);
    update(DMI_CH_ID_DMI_ACCESS);
    check("wr_req", 64'(req), 64'd1);
    check("wr_wr", 64'(req_wr), 64'd1);
    check("wr_wdata", 64'(req_wdata), 64'h12345678);
    check("wr_addr", 64'(req_addr), 64'h04);
    m_addr = 7'h04;
    do_ack(32'h0BADF00D);
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h00, 32'h0, 2'd0), so);
    check("wr_rdata_kept", so, dmi_word(7'h04, 32'hDEADBEEF, 2'b00));

    // randomized transactions
    for (int it = 0; it < 16; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = 7'($urandom_range(0, 127));
      d  = $urandom;
      capture(DMI_CH_ID_DMI_ACCESS);
      scan(41, dmi_word(a, d, op), so);
      check("rnd_capture", so, dmi_word(m_addr, m_rdata, 2'b00));
      update(DMI_CH_ID_DMI_ACCESS);
      if (op == 2'd1 || op == 2'd2) begin
        check("rnd_req", 64'(req), 64'd1);
        check("rnd_wr", 64'(req_wr), 64'(op == 2'd2));
        check("rnd_addr", 64'(req_addr), 64'(a));
        if (op == 2'd2) check("rnd_wdata", 64'(req_wdata), 64'(d));
        m_addr = a;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        r = $urandom;
        do_ack(r);
        if (op == 2'd1) m_rdata = r;
      end else begin
        check("rnd_op_ignored", 64'(req), 64'd0);
      end
    end

    // capture and ack in the same cycle: status reflects the pre-ack busy state
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h2A, 32'h0, 2'd1), so);
    update(DMI_CH_ID_DMI_ACCESS);
    check("cap_ack_req", 64'(req), 64'd1);
    r = $urandom;
    sel = 1'b1; ch_id = DMI_CH_ID_DMI_ACCESS; cap = 1'b1; ack = 1'b1; rdata = r;
    @(negedge clk);
    cap = 1'b0; ack = 1'b0;
    check("cap_ack_idle", 64'(req), 64'd0);
    scan(41, dmi_word(7'h00, 32'h0, 2'd0), so);
    check("cap_ack_stat", so, dmi_word(7'h2A, m_rdata, 2'b11));
    m_addr = 7'h2A; m_rdata = r; m_sticky = 1'b1;
    capture(DMI_CH_ID_DTMCS);
    scan(32, 64'h10000, so);
    check("dtmcs_sticky", so, 64'(dtmcs_exp(m_sticky)));
    update(DMI_CH_ID_DTMCS);
    m_sticky = 1'b0;
    capture(DMI_CH_ID_DTMCS);
    scan(32, 64'd0, so);
    check("dtmcs_cleared", so, 64'(dtmcs_exp(m_sticky)));

    // second update while a request is pending
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h33, 32'h0, 2'd1), so);
    update(DMI_CH_ID_DMI_ACCESS);
    check("busy_first_req", 64'(req), 64'd1);
    update(DMI_CH_ID_DMI_ACCESS);
    m_sticky = 1'b1;
    ack = 1'b1; rdata = $urandom;
    @(negedge clk);
    ack = 1'b0;
    capture(DMI_CH_ID_DTMCS);
    scan(32, 64'd0, so);
    check("busy_dmistat", so, 64'(dtmcs_exp(m_sticky)));
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h21, 32'h0, 2'd1), so);
    check("busy_capture_stat", 64'(so[1:0]), 64'h3);
    update(DMI_CH_ID_DMI_ACCESS);
    check("busy_update_ignored", 64'(req), 64'd0);
    capture(DMI_CH_ID_DTMCS);
    scan(32, 64'h10000, so);
    update(DMI_CH_ID_DTMCS);
    m_sticky = 1'b0;
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h00, 32'h0, 2'd0), so);
    check("busy_cleared_stat", 64'(so[1:0]), 64'h0);

    // deselected strobes and unimplemented chain ID
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h05, 32'h0, 2'd1), so);
    @(negedge clk);
    sel = 1'b0; ch_id = DMI_CH_ID_DMI_ACCESS; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    check("unsel_no_req", 64'(req), 64'd0);
    update(2'd2);
    check("id2_no_req", 64'(req), 64'd0);
    capture(2'd2);
    scan(32, 64'($urandom), so);
    check("id2_zeros", so, 64'd0);

    // reset while a request is pending
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h55, 32'h0, 2'd1), so);
    update(DMI_CH_ID_DMI_ACCESS);
    check("rstreq_req", 64'(req), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rstreq_async_drop", 64'(req), 64'd0);
    check("rstreq_tdo", 64'(tdo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_addr = '0; m_rdata = '0; m_sticky = 1'b0;
    ack = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    ack = 1'b0;
    check("rstreq_ack_ignored", 64'(req), 64'd0);
    capture(DMI_CH_ID_DMI_ACCESS);
    scan(41, dmi_word(7'h00, 32'h0, 2'd0), so);
    check("rstreq_capture", so, dmi_word(m_addr, m_rdata, 2'b00));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
